// File: rtl/shared_bram_arbiter_pkg.sv
// Shared constants for the shared BRAM arbiter:
// FSM state encoding and a ceiling-log2 helper.
package shared_bram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWN     = 2'd1;
  localparam logic [1:0] ST_HANDOFF = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_bram_arbiter_bram.sv
// Single-port LEN x WIDTH block RAM, write-first,
// one cycle read latency; contents are never reset.
module bram
  import shared_bram_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 256
) (
  input  logic                   clk,
  input  logic [clog2(LEN)-1:0]  addr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  input  logic                   we
);

  logic [WIDTH-1:0] mem [LEN];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout_q    <= din;
    end else begin
      dout_q    <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/shared_bram_arbiter.sv
// Round-robin ownership arbiter that multiplexes NCLI
// clients onto one BRAM, with optional hold-time preemption.
module shared_bram_arbiter
  import shared_bram_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LEN      = 256,
  parameter int NCLI     = 2,
  parameter int WIN_BASE = 128,
  parameter int MAX_HOLD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCLI-1:0]               cli_req,
  output logic [NCLI-1:0]               cli_gnt,
  input  logic [NCLI*clog2(LEN)-1:0]    cli_addr,
  input  logic [NCLI*WIDTH-1:0]         cli_din,
  input  logic [NCLI-1:0]               cli_we,
  input  logic [NCLI-1:0]               cli_win,
  output logic [WIDTH-1:0]              dout,
  output logic [NCLI-1:0]               rd_valid,
  output logic [NCLI-1:0]               preempt
);

  localparam int AW = clog2(LEN);
  localparam int IW = clog2(NCLI);
  localparam int HW = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NCLI-1:0] rd_valid_q, rd_valid_d;
  logic [NCLI-1:0] preempt_q, preempt_d;

  logic [NCLI-1:0] owner_oh;
  logic [NCLI-1:0] others_req;
  logic [IW-1:0]   pick;
  logic [31:0]     addr_sum;
  logic [AW-1:0]   own_addr;
  logic [AW-1:0]   bram_addr;
  logic [WIDTH-1:0] bram_din;
  logic            bram_we;

  function automatic logic [IW-1:0] rr_pick(
    input logic [NCLI-1:0] req,
    input logic [IW-1:0]   ptr
  );
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      idx = (int'(ptr) + i) % NCLI;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign owner_oh   = NCLI'(1) << owner_q;
  assign others_req = cli_req & ~owner_oh;
  assign pick       = rr_pick(cli_req, rr_ptr_q);

  // Window offset wraps modulo LEN, silently.
  assign addr_sum = 32'(cli_addr[int'(owner_q)*AW +: AW])
                  + (cli_win[owner_q] ? 32'(WIN_BASE) : 32'd0);
  assign own_addr = AW'(addr_sum % 32'(LEN));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    rd_valid_d = '0;
    preempt_d  = '0;
    bram_addr  = '0;
    bram_din   = '0;
    bram_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|cli_req) begin
          state_d = ST_OWN;
          owner_d = pick;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        bram_addr = own_addr;
        bram_din  = cli_din[int'(owner_q)*WIDTH +: WIDTH];
        bram_we   = cli_we[owner_q];
        if (!cli_we[owner_q]) begin
          rd_valid_d = owner_oh;
        end
        if (!cli_req[owner_q]) begin
          state_d = ST_HANDOFF;
        end else if (MAX_HOLD > 0 && |others_req) begin
          hold_d = hold_q + 1'b1;
          if (hold_d == HW'(MAX_HOLD)) begin
            state_d   = ST_HANDOFF;
            preempt_d = owner_oh;
          end
        end
      end
      ST_HANDOFF: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (owner_q == IW'(NCLI - 1)) ? '0 : owner_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= '0;
      rd_valid_q <= '0;
      preempt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      rd_valid_q <= rd_valid_d;
      preempt_q  <= preempt_d;
    end
  end

  assign cli_gnt  = (state_q == ST_OWN) ? owner_oh : '0;
  assign rd_valid = rd_valid_q;
  assign preempt  = preempt_q;

  // Write is gated by reset so a reset edge never commits data.
  bram #(
    .WIDTH (WIDTH),
    .LEN   (LEN)
  ) u_bram (
    .clk  (clk),
    .addr (bram_addr),
    .din  (bram_din),
    .dout (dout),
    .we   (bram_we & rst_n)
  );

endmodule

// File: tb/tb_shared_bram_arbiter.sv
// Directed cycle table plus randomized run against a
// behavioural model of the shared BRAM arbiter.
module tb_shared_bram_arbiter;

  localparam int W   = 8;
  localparam int LEN = 256;
  localparam int N   = 2;
  localparam int AW  = 8;
  localparam int MH  = 4;
  localparam int WB  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    cli_req, cli_gnt, cli_we, cli_win;
  logic [N-1:0]    rd_valid, preempt;
  logic [N*AW-1:0] cli_addr;
  logic [N*W-1:0]  cli_din;
  logic [W-1:0]    dout;

  shared_bram_arbiter #(
    .WIDTH    (W),
    .LEN      (LEN),
    .NCLI     (N),
    .WIN_BASE (WB),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cli_req  (cli_req),
    .cli_gnt  (cli_gnt),
    .cli_addr (cli_addr),
    .cli_din  (cli_din),
    .cli_we   (cli_we),
    .cli_win  (cli_win),
    .dout     (dout),
    .rd_valid (rd_valid),
    .preempt  (preempt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic       rst;
    logic [1:0] req, we, win;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] gnt, rdv, pre;
    logic       cd;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input int r, input int req, input int we, input int win,
    input int a0, input int a1, input int d0, input int d1,
    input int gnt, input int rdv, input int pre,
    input int cd, input int dt);
    vec_t x;
    x.rst = 1'(r);   x.req = 2'(req); x.we = 2'(we);
    x.win = 2'(win); x.a0 = 8'(a0);   x.a1 = 8'(a1);
    x.d0 = 8'(d0);   x.d1 = 8'(d1);   x.gnt = 2'(gnt);
    x.rdv = 2'(rdv); x.pre = 2'(pre); x.cd = 1'(cd);
    x.dout = 8'(dt);
    return x;
  endfunction

  // model state
  logic [7:0] mem [LEN];
  bit         known [LEN];
  bit         m_busy, m_hand;
  int         m_own, m_rr, m_hold;
  logic [7:0] r_addr [N];
  logic [7:0] r_din [N];

  initial begin
    rst_n = 1'b0; cli_req = '0; cli_we = '0; cli_win = '0;
    cli_addr = '0; cli_din = '0;

    // rst req we win a0 a1 d0 d1 | gnt rdv pre chk dout
    tbl.push_back(v(0,0,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 0,0,0,0,       1,0,0,0,0));
    tbl.push_back(v(1,1,1,1, 3,0,'hA5,0,    1,0,0,0,0));
    tbl.push_back(v(1,0,0,1, 3,0,0,0,       0,1,0,1,'hA5));
    tbl.push_back(v(1,2,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,131,0,0,     2,0,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,131,0,0,     2,2,0,1,'hA5));
    tbl.push_back(v(1,0,0,0, 0,131,0,0,     0,2,0,1,'hA5));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(0,3,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 0,0,0,0,       1,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 0,0,0,0,       1,1,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,0,0,0,       0,1,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,0,0,0,       2,0,0,0,0));
    tbl.push_back(v(1,2,2,0, 0,7,0,'h3C,    2,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 0,7,0,0,       0,2,0,1,'h3C));
    tbl.push_back(v(1,1,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 0,0,0,0,       1,0,0,0,0));
    tbl.push_back(v(1,3,3,1, 200,7,'h5A,'hFF, 1,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 7,0,0,0,       1,1,0,1,'h3C));
    tbl.push_back(v(1,1,0,0, 72,0,0,0,      1,1,0,1,'h5A));
    tbl.push_back(v(1,0,0,0, 72,0,0,0,      0,1,0,1,'h5A));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 72,0,0,0,      1,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 72,0,0,0,      1,1,0,1,'h5A));
    tbl.push_back(v(1,3,0,0, 72,0,0,0,      1,1,0,1,'h5A));
    tbl.push_back(v(1,3,0,0, 72,0,0,0,      1,1,0,1,'h5A));
    tbl.push_back(v(1,3,0,0, 72,0,0,0,      0,1,1,1,'h5A));
    tbl.push_back(v(1,3,0,0, 72,72,0,0,     0,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 72,72,0,0,     2,0,0,0,0));
    tbl.push_back(v(1,3,0,0, 72,72,0,0,     2,2,0,1,'h5A));
    tbl.push_back(v(1,1,0,0, 72,72,0,0,     0,2,0,1,'h5A));
    tbl.push_back(v(1,1,0,0, 0,0,0,0,       0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 72,0,0,0,      1,0,0,0,0));
    tbl.push_back(v(0,1,1,0, 72,0,'hEE,0,   0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 72,0,0,0,      1,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 72,0,0,0,      1,1,0,1,'h5A));
    tbl.push_back(v(1,0,0,0, 72,0,0,0,      0,1,0,1,'h5A));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,       0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n    = tbl[i].rst;
      cli_req  = tbl[i].req;
      cli_we   = tbl[i].we;
      cli_win  = tbl[i].win;
      cli_addr = {tbl[i].a1, tbl[i].a0};
      cli_din  = {tbl[i].d1, tbl[i].d0};
      @(posedge clk);
      #1;
      chk($sformatf("v%0d gnt", i), 32'(cli_gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d rdv", i), 32'(rd_valid), 32'(tbl[i].rdv));
      chk($sformatf("v%0d pre", i), 32'(preempt), 32'(tbl[i].pre));
      if (tbl[i].cd)
        chk($sformatf("v%0d dout", i), 32'(dout), 32'(tbl[i].dout));
    end

    // randomized phase against the behavioural model
    for (int a = 0; a < LEN; a++) known[a] = 1'b0;
    m_busy = 0; m_hand = 0; m_own = 0; m_rr = 0; m_hold = 0;
    cli_req = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] e_gnt, e_rdv, e_pre;
      logic [7:0]   e_dout;
      bit           e_cd;
      int           ad;
      rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(149) != 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5) == 0) cli_req[c] = ~cli_req[c];
        cli_we[c]  = ($urandom_range(2) == 0);
        cli_win[c] = 1'($urandom_range(1));
        r_addr[c]  = 8'($urandom_range(255));
        r_din[c]   = 8'($urandom_range(255));
        cli_addr[c*AW +: AW] = r_addr[c];
        cli_din[c*W +: W]    = r_din[c];
      end
      e_rdv = '0; e_pre = '0; e_cd = 0; e_dout = '0;
      if (!rst_n) begin
        m_busy = 0; m_hand = 0; m_rr = 0; m_hold = 0;
      end else if (m_hand) begin
        m_rr = (m_own + 1) % N;
        m_hand = 0;
      end else if (m_busy) begin
        ad = (int'(r_addr[m_own]) + (cli_win[m_own] ? WB : 0)) % LEN;
        if (cli_we[m_own]) begin
          mem[ad] = r_din[m_own];
          known[ad] = 1'b1;
        end else begin
          e_rdv[m_own] = 1'b1;
          if (known[ad]) begin
            e_cd = 1;
            e_dout = mem[ad];
          end
        end
        if (!cli_req[m_own]) begin
          m_busy = 0; m_hand = 1;
        end else if ((cli_req & ~(N'(1) << m_own)) != 0) begin
          m_hold++;
          if (m_hold == MH) begin
            m_busy = 0; m_hand = 1;
            e_pre[m_own] = 1'b1;
          end
        end
      end else if (cli_req != 0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (cli_req[(m_rr + k) % N]) m_own = (m_rr + k) % N;
        end
        m_busy = 1;
        m_hold = 0;
      end
      e_gnt = m_busy ? (N'(1) << m_own) : '0;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d gnt", cyc), 32'(cli_gnt), 32'(e_gnt));
      chk($sformatf("r%0d rdv", cyc), 32'(rd_valid), 32'(e_rdv));
      chk($sformatf("r%0d pre", cyc), 32'(preempt), 32'(e_pre));
      if (e_cd)
        chk($sformatf("r%0d dout", cyc), 32'(dout), 32'(e_dout));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
